words_checker: RTL and testbench
================================

# words_checker

Streaming word-rule checker implementing module `words`. It consumes one byte per clock from a NUL-delimited character stream, tracks the word in progress and, when a word terminates, pulses `valid` if the word obeyed the spelling rules (every Q immediately followed by U, length within bound). It sits behind a byte source such as a UART or ROM reader and feeds a word counter or filter downstream.

## Interface
Parameters:
- `MAX_LEN`, 32: maximum characters per word; longer words are invalid.

Ports:
- `clock`  input  1  sole clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-low reset (asserted when 0).
- `words`  input  8  stream byte sampled every rising edge; 8'd0 = word terminator, any non-zero = character.
- `valid`  output 1  registered; one-cycle pulse marking a completed word that passed all rules.

## Operation
- No input handshake: a byte is consumed on every rising edge while reset is deasserted.
- FSM states:
  - EMPTY: no characters since last terminator.
  - IN_WORD: characters seen, no rule broken, last char not Q.
  - AFTER_Q: last char was Q, awaiting U.
  - BAD: rule broken; wait for terminator.
- Transitions on sampled byte b:
  - b == 0: valid <= (state == IN_WORD); state -> EMPTY; length cleared.
  - From EMPTY/IN_WORD, b != 0: Q -> AFTER_Q; otherwise -> IN_WORD.
  - From AFTER_Q: U -> IN_WORD; any other non-zero -> BAD.
  - From BAD: non-zero stays BAD.
  - Any state: if this character makes length exceed `MAX_LEN` -> BAD.
- Q = 8'd81, U = 8'd85 (see Configuration for lowercase).
- Length counter: $clog2(MAX_LEN+1)+1 bits, saturates at MAX_LEN+1, never wraps.
- Boundary cases:
  - Word ending in Q (AFTER_Q at terminator): invalid, valid stays 0.
  - Empty word (consecutive 0 bytes): valid stays 0.
  - "QQU": second Q in AFTER_Q is not U -> BAD.
  - Word of exactly `MAX_LEN` characters: valid; `MAX_LEN`+1: invalid.

## Timing
- Reset: state = EMPTY, length = 0, valid = 0, applied immediately on reset falling to 0, held while low.
- Reset asserted mid-word discards that word; no pulse is generated for it.
- First byte is sampled on the first rising edge after reset deasserts.
- Latency: `valid` rises on the same edge that samples the terminator; visible the cycle after the 0 is presented, for exactly one cycle.
- Back-to-back words with single 0 separators yield at most one pulse per terminator; no dead cycles.

## Configuration
- `WORDS_LOWERCASE_EN`:
  - Defined: Q matches 8'd81 or 8'd113; U matches 8'd85 or 8'd117, any case combination ("qU", "Qu" valid).
  - Undefined: only uppercase 81/85 recognized; lowercase 'q' is an ordinary character.

## Test plan
- Reset held low 2 cycles with input 0 -> valid = 0 throughout; release, feed eight 0 bytes -> valid never pulses.
- Feed 1, 2, 0 -> single valid pulse one cycle after the 0 is sampled.
- Feed 81, 1, 0 ("Qx") -> no pulse; then 81, 85, 0 ("QU") -> one pulse.
- Feed 81, 0 and 81, 81, 85, 0 -> no pulses.
- With `MAX_LEN`=4: 1,1,1,1,0 -> pulse; 1,1,1,1,1,0 -> no pulse; then 1,0 -> pulse (recovery).
- Assert reset low mid-word after 81 -> valid 0 immediately; after release, 85, 0 -> pulse (Q forgotten). With `WORDS_LOWERCASE_EN`: 113, 117, 0 -> pulse; without it: 113, 1, 0 -> pulse.

Source files
------------

// File: rtl/words_checker.sv
// words_checker: streaming word-rule checker.
// Consumes one byte per clock; 8'd0 terminates a word. When a word ends,
// 'valid' pulses for one cycle if every Q in it was immediately followed by U
// and it held no more than MAX_LEN characters.
// Optional feature macro: WORDS_LOWERCASE_EN
//   Defined:   lowercase q/u (113/117) are treated like Q/U.
//   Undefined: only uppercase Q/U (81/85) are recognised.
//
// state   | meaning
// --------+------------------------------------------------------
// EMPTY   | no characters since the last terminator
// IN_WORD | characters seen, no rule broken, last char not Q
// AFTER_Q | last char was Q, the next one must be U
// BAD     | a rule was broken; wait for the terminator

module words_checker #(
   parameter int MAX_LEN = 32
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] words,
   output logic       valid
);

   localparam int LW = $clog2(MAX_LEN + 1) + 1;
   localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
   localparam logic [LW-1:0] LEN_SAT = LW'(MAX_LEN + 1);

   localparam logic [7:0] CHAR_Q_UP = 8'd81;
   localparam logic [7:0] CHAR_U_UP = 8'd85;
`ifdef WORDS_LOWERCASE_EN
   localparam logic [7:0] CHAR_Q_LO = 8'd113;
   localparam logic [7:0] CHAR_U_LO = 8'd117;
`endif

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      IN_WORD = 2'd1,
      AFTER_Q = 2'd2,
      BAD     = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [LW-1:0]   len_q, len_d;
   logic            valid_q, valid_d;
   logic            q_char;
   logic            u_char;

   // Character class decode for the byte currently on the input.
   always_comb begin
`ifdef WORDS_LOWERCASE_EN
      q_char = (words == CHAR_Q_UP) || (words == CHAR_Q_LO);
      u_char = (words == CHAR_U_UP) || (words == CHAR_U_LO);
`else
      q_char = (words == CHAR_Q_UP);
      u_char = (words == CHAR_U_UP);
`endif
   end

   // Next-state, length and pulse computation for the sampled byte.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      valid_d = 1'b0;
      if (words == 8'd0) begin
         valid_d = (state_q == IN_WORD);
         state_d = EMPTY;
         len_d   = '0;
      end else begin
         // Saturate so an arbitrarily long word can never wrap back into range.
         if (len_q != LEN_SAT) begin
            len_d = len_q + LW'(1);
         end
         case (state_q)
            EMPTY, IN_WORD: state_d = q_char ? AFTER_Q : IN_WORD;
            AFTER_Q:        state_d = u_char ? IN_WORD : BAD;
            default:        state_d = BAD;
         endcase
         // This character would be number MAX_LEN+1 or beyond.
         if (len_q >= LEN_MAX) begin
            state_d = BAD;
         end
      end
   end

   // State, length and output registers; reset clears any word in progress.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= EMPTY;
         len_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         valid_q <= valid_d;
      end
   end

   assign valid = valid_q;

endmodule

// File: tb/tb_words_checker.sv
// Testbench for words_checker (MAX_LEN = 4). The driver pushes the expected
// 'valid' value for each byte it presents; the monitor pops one expectation
// per clock shortly after the sampling edge and compares.

module tb_words_checker;

   localparam int MAX_LEN = 4;

   logic       clock;
   logic       reset;
   logic [7:0] words;
   logic       valid;

   int checks   = 0;
   int failures = 0;

   bit exp_q[$];

   words_checker #(.MAX_LEN(MAX_LEN)) dut (
      .clock (clock),
      .reset (reset),
      .words (words),
      .valid (valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Present one byte for the next rising edge and record the expected pulse.
   task automatic send(input logic [7:0] b, input bit exp);
      @(negedge clock);
      words = b;
      exp_q.push_back(exp);
   endtask

   task automatic check_now(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: valid=%0b expected=%0b at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: one expectation is consumed per clock, 1 time unit after the edge.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            bit e;
            e = exp_q.pop_front();
            check_now("stream", valid, e);
         end
      end
   end

   initial begin
      reset = 1'b0;
      words = 8'd0;
      #1;
      check_now("reset_initial", valid, 1'b0);
      send(8'd0, 1'b0);
      send(8'd0, 1'b0);

      // Release, then a run of empty words.
      @(negedge clock);
      reset = 1'b1;
      words = 8'd0;
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) send(8'd0, 1'b0);

      // Plain word.
      send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd0, 1'b1);
      // "Qx" invalid, then "QU" valid.
      send(8'd81, 1'b0); send(8'd1, 1'b0); send(8'd0, 1'b0);
      send(8'd81, 1'b0); send(8'd85, 1'b0); send(8'd0, 1'b1);
      // Word ending in Q, and "QQU".
      send(8'd81, 1'b0); send(8'd0, 1'b0);
      send(8'd81, 1'b0); send(8'd81, 1'b0); send(8'd85, 1'b0); send(8'd0, 1'b0);
      // Back-to-back single-separator words.
      send(8'd7, 1'b0); send(8'd0, 1'b1); send(8'd8, 1'b0); send(8'd0, 1'b1);

      // Length bounds with MAX_LEN = 4.
      for (int i = 0; i < 4; i++) send(8'd1, 1'b0);
      send(8'd0, 1'b1);
      for (int i = 0; i < 5; i++) send(8'd1, 1'b0);
      send(8'd0, 1'b0);
      send(8'd1, 1'b0); send(8'd0, 1'b1);
      // Very long word must not wrap the length back into range.
      for (int i = 0; i < 20; i++) send(8'd1, 1'b0);
      send(8'd0, 1'b0);
      // "xxxQU" is 5 characters: over length even though Q/U rule holds.
      send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0);
      send(8'd81, 1'b0); send(8'd85, 1'b0); send(8'd0, 1'b0);
      // "xxQU" is exactly 4 characters.
      send(8'd1, 1'b0); send(8'd1, 1'b0);
      send(8'd81, 1'b0); send(8'd85, 1'b0); send(8'd0, 1'b1);

      // Reset falling while valid is high clears it immediately.
      send(8'd5, 1'b0); send(8'd0, 1'b1);
      @(negedge clock);
      reset = 1'b0;
      words = 8'd0;
      exp_q.push_back(1'b0);
      #1;
      check_now("reset_async_clear", valid, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      exp_q.push_back(1'b0);

      // Reset mid-word after Q forgets the Q.
      send(8'd81, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      words = 8'd85;
      exp_q.push_back(1'b0);
      #1;
      check_now("reset_mid_word", valid, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      words = 8'd0;
      exp_q.push_back(1'b0);
      send(8'd85, 1'b0); send(8'd0, 1'b1);

`ifdef WORDS_LOWERCASE_EN
      send(8'd113, 1'b0); send(8'd117, 1'b0); send(8'd0, 1'b1);
      send(8'd113, 1'b0); send(8'd85, 1'b0); send(8'd0, 1'b1);
      send(8'd81, 1'b0); send(8'd117, 1'b0); send(8'd0, 1'b1);
      send(8'd113, 1'b0); send(8'd1, 1'b0); send(8'd0, 1'b0);
`else
      send(8'd113, 1'b0); send(8'd1, 1'b0); send(8'd0, 1'b1);
      send(8'd81, 1'b0); send(8'd117, 1'b0); send(8'd0, 1'b0);
`endif
      send(8'd0, 1'b0);

      // Bounded drain of outstanding expectations.
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clock);
      #2;
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: pending=%0d expected=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
